// File: rtl/dmem_write_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_write_responder_if
//   Bundles every signal between the store buffer / load pipe / backing
//   memory and the write responder.
//
//   Handshake: a head entry transfers to backing memory on any rising clock
//   edge where bus_valid && bus_ready. While bus_valid is high and bus_ready
//   is low, bus_addr/bus_data/bus_be hold their values. Writes use
//   mem_wr_en as a one-cycle strobe; the producer must hold off while
//   wr_stall is high.
//
//   Modports:
//     slave  - the responder (consumes writes/loads/ready, drives status/bus)
//     master - the environment driving writes and loads and acting as memory
// ---------------------------------------------------------------------------
interface dmem_write_responder_if #(
    parameter int CNT_W = 3
);
    logic             mem_wr_en;
    logic [31:0]      mem_wr_addr;
    logic [31:0]      mem_wr_data;
    logic [3:0]       mem_wr_byte_enable;
    logic             wr_stall;
    logic             load_req;
    logic [31:0]      load_addr;
    logic             load_hazard;
    logic             bus_valid;
    logic             bus_ready;
    logic [31:0]      bus_addr;
    logic [31:0]      bus_data;
    logic [3:0]       bus_be;
    logic [CNT_W-1:0] pending;
    logic             overflow_err;

    modport slave (
        input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_byte_enable,
        input  load_req, load_addr, bus_ready,
        output wr_stall, load_hazard, bus_valid, bus_addr, bus_data, bus_be,
        output pending, overflow_err
    );

    modport master (
        output mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_byte_enable,
        output load_req, load_addr, bus_ready,
        input  wr_stall, load_hazard, bus_valid, bus_addr, bus_data, bus_be,
        input  pending, overflow_err
    );
endinterface

// File: rtl/dmem_write_responder.sv
// ---------------------------------------------------------------------------
// dmem_write_responder
//   Circular write queue between a store buffer and backing memory.
//   Writes to the same word as the newest entry merge into it; otherwise
//   they take a new slot. The oldest entry is presented on the bus and
//   retired on bus_valid && bus_ready. Loads are checked against every
//   queued word address to flag read-after-write hazards.
//
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset, clears the queue and error flag
//     bus    - dmem_write_responder_if.slave (write, load, memory and status)
// ---------------------------------------------------------------------------
module dmem_write_responder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dmem_write_responder_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       be_q   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             ovf_q, ovf_d;

    logic             full;
    logic             pop;
    logic             wr_act;
    logic             merge;
    logic             enq;
    logic [PTR_W-1:0] last_idx;
    logic [PTR_W-1:0] offs;
    logic             hazard;
    logic [31:0]      lane_mask;

    // Low address bits carry no meaning for word-granular storage.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.mem_wr_addr[1:0], bus.load_addr[1:0]};

    always_comb begin
        full      = (pending_q == CNT_FULL);
        pop       = (pending_q != '0) && bus.bus_ready;
        wr_act    = bus.mem_wr_en && (bus.mem_wr_byte_enable != 4'b0000);
        last_idx  = tail_q - PTR_ONE;
        // When only one entry is queued the newest entry is also the head;
        // if it leaves this cycle the write must not land in it.
        merge     = wr_act && (pending_q != '0)
                    && (addr_q[last_idx] == bus.mem_wr_addr[31:2])
                    && !(pop && (pending_q == CNT_W'(1)));
        enq       = wr_act && !merge && !full;
        lane_mask = {{8{bus.mem_wr_byte_enable[3]}}, {8{bus.mem_wr_byte_enable[2]}},
                     {8{bus.mem_wr_byte_enable[1]}}, {8{bus.mem_wr_byte_enable[0]}}};

        head_d    = pop ? head_q + PTR_ONE : head_q;
        tail_d    = enq ? tail_q + PTR_ONE : tail_q;
        pending_d = pending_q + CNT_W'(enq) - CNT_W'(pop);
        ovf_d     = ovf_q || (wr_act && !merge && full);
    end

    // Hazard scan: slot i is live when its distance from head is below the
    // occupancy. The write arriving this cycle is not yet in any slot.
    always_comb begin
        hazard = 1'b0;
        offs   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PTR_W'(i) - head_q;
            if ((CNT_W'(offs) < pending_q) && (addr_q[i] == bus.load_addr[31:2]))
                hazard = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            if (enq) begin
                addr_q[tail_q] <= bus.mem_wr_addr[31:2];
                data_q[tail_q] <= bus.mem_wr_data;
                be_q[tail_q]   <= bus.mem_wr_byte_enable;
            end
            if (merge) begin
                data_q[last_idx] <= (data_q[last_idx] & ~lane_mask)
                                    | (bus.mem_wr_data & lane_mask);
                be_q[last_idx]   <= be_q[last_idx] | bus.mem_wr_byte_enable;
            end
        end
    end

    assign bus.wr_stall     = full;
    assign bus.bus_valid    = (pending_q != '0);
    assign bus.bus_addr     = {addr_q[head_q], 2'b00};
    assign bus.bus_data     = data_q[head_q];
    assign bus.bus_be       = be_q[head_q];
    assign bus.pending      = pending_q;
    assign bus.overflow_err = ovf_q;
    assign bus.load_hazard  = bus.load_req && hazard;
endmodule

// File: tb/tb_dmem_write_responder.sv
module tb_dmem_write_responder;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   use_model = 0;

    dmem_write_responder_if #(.CNT_W(CNT_W)) dif ();

    dmem_write_responder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;

    entry_t model_q[$];
    bit     model_ovf;

    // scoreboard of {addr, data} expected to leave on the bus, in order
    logic [63:0] exp_q[$];

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic idle_inputs();
        dif.mem_wr_en          = 1'b0;
        dif.mem_wr_addr        = '0;
        dif.mem_wr_data        = '0;
        dif.mem_wr_byte_enable = '0;
        dif.load_req           = 1'b0;
        dif.load_addr          = '0;
        dif.bus_ready          = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_q.delete();
        model_ovf = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called just after a falling edge: drives one cycle of inputs, samples
    // outputs before the next rising edge, then advances the model.
    task automatic apply(input logic wr_en, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input logic ready, input logic lreq,
                         input logic [31:0] laddr);
        int     sz;
        bit     pop;
        bit     hz;
        entry_t e;
        dif.mem_wr_en          = wr_en;
        dif.mem_wr_addr        = addr;
        dif.mem_wr_data        = data;
        dif.mem_wr_byte_enable = be;
        dif.bus_ready          = ready;
        dif.load_req           = lreq;
        dif.load_addr          = laddr;
        #1;
        sz = model_q.size();
        if (use_model) begin
            hz = 0;
            foreach (model_q[k]) if (model_q[k].waddr == laddr[31:2]) hz = 1;
            hz = hz && lreq;
            check("m_pending", 32'(dif.pending), 32'(sz));
            check("m_valid", 32'(dif.bus_valid), 32'(sz > 0));
            check("m_stall", 32'(dif.wr_stall), 32'(sz == DEPTH));
            check("m_ovf", 32'(dif.overflow_err), 32'(model_ovf));
            check("m_hazard", 32'(dif.load_hazard), 32'(hz));
            if (sz > 0) begin
                check("m_addr", dif.bus_addr, {model_q[0].waddr, 2'b00});
                check("m_be", 32'(dif.bus_be), 32'(model_q[0].be));
                check("m_data", dif.bus_data & be_mask(model_q[0].be),
                      model_q[0].data & be_mask(model_q[0].be));
            end
        end
        pop = (sz > 0) && ready;
        if (wr_en && be != 4'b0000) begin
            if (sz > 0 && model_q[sz-1].waddr == addr[31:2] && !(pop && sz == 1)) begin
                e = model_q[sz-1];
                e.data = (e.data & ~be_mask(be)) | (data & be_mask(be));
                e.be   = e.be | be;
                model_q[sz-1] = e;
            end else if (sz < DEPTH) begin
                model_q.push_back('{addr[31:2], data, be});
            end else begin
                model_ovf = 1;
            end
        end
        if (pop) void'(model_q.pop_front());
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        wr_en;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        ready;
        logic        lreq;
        logic [31:0] laddr;
        int          e_pend;
        logic        e_stall;
        logic        e_haz;
        logic        e_ovf;
        logic        chk_bus;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic [3:0]  e_be;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic wr_en, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] be, input logic ready, input logic lreq,
                               input logic [31:0] laddr, input int e_pend, input logic e_stall,
                               input logic e_haz, input logic e_ovf, input logic chk_bus,
                               input logic [31:0] e_addr, input logic [31:0] e_data,
                               input logic [3:0] e_be);
        vec_t r;
        r.wr_en = wr_en; r.addr = addr; r.data = data; r.be = be; r.ready = ready;
        r.lreq = lreq; r.laddr = laddr; r.e_pend = e_pend; r.e_stall = e_stall;
        r.e_haz = e_haz; r.e_ovf = e_ovf; r.chk_bus = chk_bus; r.e_addr = e_addr;
        r.e_data = e_data; r.e_be = e_be;
        return r;
    endfunction

    initial begin
        int idx;
        int cyc;
        logic [63:0] exp_item;

        rst_n = 1'b0;
        idle_inputs();

        //             wr addr   data          be    rdy lrq laddr  pend st hz ov cb e_addr e_data        e_be
        // single write, drained next cycle
        vecs.push_back(v(1, 32'h100, 32'hDEADBEEF, 4'hF, 1, 0, 32'h0,   0, 0, 0, 0, 1, 32'h0,   32'h0,        4'h0));
        vecs.push_back(v(0, 32'h0,   32'h0,        4'h0, 1, 0, 32'h0,   1, 0, 0, 0, 1, 32'h100, 32'hDEADBEEF, 4'hF));
        vecs.push_back(v(0, 32'h0,   32'h0,        4'h0, 1, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,   32'h0,        4'h0));
        // merge of two partial writes to one word
        vecs.push_back(v(1, 32'h200, 32'h000000AA, 4'h1, 0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,   32'h0,        4'h0));
        vecs.push_back(v(1, 32'h202, 32'h00BB0000, 4'h4, 0, 0, 32'h0,   1, 0, 0, 0, 1, 32'h200, 32'h000000AA, 4'h1));
        vecs.push_back(v(0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h0,   1, 0, 0, 0, 1, 32'h200, 32'h00BB00AA, 4'h5));
        vecs.push_back(v(0, 32'h0,   32'h0,        4'h0, 1, 0, 32'h0,   1, 0, 0, 0, 0, 32'h0,   32'h0,        4'h0));
        vecs.push_back(v(0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,   32'h0,        4'h0));
        // fill, overflow drop, merge while full, drain
        vecs.push_back(v(1, 32'h0,   32'h11111111, 4'hF, 0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,   32'h0,        4'h0));
        vecs.push_back(v(1, 32'h4,   32'h22222222, 4'hF, 0, 0, 32'h0,   1, 0, 0, 0, 0, 32'h0,   32'h0,        4'h0));
        vecs.push_back(v(1, 32'h8,   32'h33333333, 4'hF, 0, 0, 32'h0,   2, 0, 0, 0, 0, 32'h0,   32'h0,        4'h0));
        vecs.push_back(v(1, 32'hC,   32'h44444444, 4'hF, 0, 0, 32'h0,   3, 0, 0, 0, 0, 32'h0,   32'h0,        4'h0));
        vecs.push_back(v(1, 32'h10,  32'h55555555, 4'hF, 0, 0, 32'h0,   4, 1, 0, 0, 0, 32'h0,   32'h0,        4'h0));
        vecs.push_back(v(1, 32'hC,   32'h0000AB00, 4'h2, 0, 0, 32'h0,   4, 1, 0, 1, 1, 32'h0,   32'h11111111, 4'hF));
        vecs.push_back(v(0, 32'h0,   32'h0,        4'h0, 0, 1, 32'hE,   4, 1, 1, 1, 0, 32'h0,   32'h0,        4'h0));
        vecs.push_back(v(0, 32'h0,   32'h0,        4'h0, 1, 1, 32'h10,  4, 1, 0, 1, 0, 32'h0,   32'h0,        4'h0));
        vecs.push_back(v(0, 32'h0,   32'h0,        4'h0, 1, 0, 32'h0,   3, 0, 0, 1, 1, 32'h4,   32'h22222222, 4'hF));
        vecs.push_back(v(0, 32'h0,   32'h0,        4'h0, 1, 0, 32'h0,   2, 0, 0, 1, 0, 32'h0,   32'h0,        4'h0));
        vecs.push_back(v(0, 32'h0,   32'h0,        4'h0, 1, 0, 32'h0,   1, 0, 0, 1, 1, 32'hC,   32'h4444AB44, 4'hF));
        vecs.push_back(v(0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h0,   0, 0, 0, 1, 0, 32'h0,   32'h0,        4'h0));
        // load hazard, including same-cycle write exclusion and pop cycle
        vecs.push_back(v(1, 32'h300, 32'h00000030, 4'hF, 0, 1, 32'h300, 0, 0, 0, 1, 0, 32'h0,   32'h0,        4'h0));
        vecs.push_back(v(0, 32'h0,   32'h0,        4'h0, 0, 1, 32'h302, 1, 0, 1, 1, 1, 32'h300, 32'h00000030, 4'hF));
        vecs.push_back(v(0, 32'h0,   32'h0,        4'h0, 0, 1, 32'h304, 1, 0, 0, 1, 0, 32'h0,   32'h0,        4'h0));
        vecs.push_back(v(0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h300, 1, 0, 0, 1, 0, 32'h0,   32'h0,        4'h0));
        vecs.push_back(v(0, 32'h0,   32'h0,        4'h0, 1, 1, 32'h300, 1, 0, 1, 1, 0, 32'h0,   32'h0,        4'h0));
        vecs.push_back(v(0, 32'h0,   32'h0,        4'h0, 0, 1, 32'h300, 0, 0, 0, 1, 0, 32'h0,   32'h0,        4'h0));
        // zero byte-enable is ignored
        vecs.push_back(v(1, 32'h400, 32'hFFFFFFFF, 4'h0, 0, 0, 32'h0,   0, 0, 0, 1, 0, 32'h0,   32'h0,        4'h0));
        vecs.push_back(v(0, 32'h0,   32'h0,        4'h0, 0, 1, 32'h400, 0, 0, 0, 1, 0, 32'h0,   32'h0,        4'h0));
        // same-word write while the only entry departs enqueues fresh
        vecs.push_back(v(1, 32'h500, 32'h00000005, 4'h1, 0, 0, 32'h0,   0, 0, 0, 1, 0, 32'h0,   32'h0,        4'h0));
        vecs.push_back(v(1, 32'h500, 32'h00000600, 4'h2, 1, 0, 32'h0,   1, 0, 0, 1, 1, 32'h500, 32'h00000005, 4'h1));
        vecs.push_back(v(0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h0,   1, 0, 0, 1, 1, 32'h500, 32'h00000600, 4'h2));
        vecs.push_back(v(0, 32'h0,   32'h0,        4'h0, 1, 0, 32'h0,   1, 0, 0, 1, 0, 32'h0,   32'h0,        4'h0));
        vecs.push_back(v(0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h0,   0, 0, 0, 1, 0, 32'h0,   32'h0,        4'h0));

        do_reset();

        foreach (vecs[i]) begin
            @(negedge clk);
            apply(vecs[i].wr_en, vecs[i].addr, vecs[i].data, vecs[i].be,
                  vecs[i].ready, vecs[i].lreq, vecs[i].laddr);
            check($sformatf("v%0d_pending", i), 32'(dif.pending), 32'(vecs[i].e_pend));
            check($sformatf("v%0d_valid", i), 32'(dif.bus_valid), 32'(vecs[i].e_pend != 0));
            check($sformatf("v%0d_stall", i), 32'(dif.wr_stall), 32'(vecs[i].e_stall));
            check($sformatf("v%0d_hazard", i), 32'(dif.load_hazard), 32'(vecs[i].e_haz));
            check($sformatf("v%0d_ovf", i), 32'(dif.overflow_err), 32'(vecs[i].e_ovf));
            if (vecs[i].chk_bus) begin
                check($sformatf("v%0d_addr", i), dif.bus_addr, vecs[i].e_addr);
                check($sformatf("v%0d_data", i), dif.bus_data, vecs[i].e_data);
                check($sformatf("v%0d_be", i), 32'(dif.bus_be), 32'(vecs[i].e_be));
            end
        end

        // ---------------- wrap: 10 writes, ready toggling ----------------
        do_reset();
        use_model = 1;
        idx = 0;
        cyc = 0;
        exp_q.delete();
        while ((idx < 10 || exp_q.size() != 0) && cyc < 200) begin
            @(negedge clk);
            if (idx < 10 && !dif.wr_stall) begin
                exp_item = {32'h1000 + 32'(idx * 4), $urandom()};
                exp_q.push_back(exp_item);
                apply(1, exp_item[63:32], exp_item[31:0], 4'hF, cyc[0], 0, 32'h0);
                idx++;
            end else begin
                apply(0, 32'h0, 32'h0, 4'h0, cyc[0], 0, 32'h0);
            end
            if (dif.bus_valid && dif.bus_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_pop", 32'(dif.bus_valid), 32'h0);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("sb_addr", dif.bus_addr, exp_item[63:32]);
                    check("sb_data", dif.bus_data, exp_item[31:0]);
                end
            end
            cyc++;
        end
        check("wrap_all_drained", 32'(exp_q.size()), 32'h0);
        check("wrap_all_sent", 32'(idx), 32'd10);
        @(negedge clk);
        apply(0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0);
        check("wrap_pending_zero", 32'(dif.pending), 32'h0);

        // ---------------- reset mid-drain ----------------
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            apply(1, 32'h20 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF, 0, 0, 32'h0);
        end
        @(negedge clk);
        apply(0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0);
        @(negedge clk);
        idle_inputs();
        dif.bus_ready = 1'b1;
        dif.load_req  = 1'b1;
        dif.load_addr = 32'h24;
        #1;
        check("pre_rst_pending", 32'(dif.pending), 32'd3);
        check("pre_rst_ovf", 32'(dif.overflow_err), 32'h1);
        check("pre_rst_hazard", 32'(dif.load_hazard), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(dif.bus_valid), 32'h0);
        check("rst_pending", 32'(dif.pending), 32'h0);
        check("rst_ovf", 32'(dif.overflow_err), 32'h0);
        check("rst_stall", 32'(dif.wr_stall), 32'h0);
        check("rst_hazard", 32'(dif.load_hazard), 32'h0);
        check("rst_addr", dif.bus_addr, 32'h0);
        check("rst_data", dif.bus_data, 32'h0);
        check("rst_be", 32'(dif.bus_be), 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold_valid", 32'(dif.bus_valid), 32'h0);
        model_q.delete();
        model_ovf = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- randomized against model ----------------
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            apply(($urandom_range(0, 9) < 7), 32'h800 + 32'($urandom_range(0, 23)), $urandom(),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), 32'h800 + 32'($urandom_range(0, 23)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_write_responder.md
DMEM_WRITE_RESPONDER -- requirements
Module: dmem_write_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of write-queue entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 3, width of the occupancy count (log2(DEPTH)+1).
REQ-003 SHALL use a single clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 mem_wr_en  input  1  write request from store buffer, one write per asserted cycle.
REQ-007 mem_wr_addr  input  32  byte address of write (bits [1:0] ignored).
REQ-008 mem_wr_data  input  32  write data, lane i = bits [8i+7:8i].
REQ-009 mem_wr_byte_enable  input  4  byte-lane enables.
REQ-010 wr_stall  output  1  queue full; upstream SHALL hold further writes.
REQ-011 load_req  input  1  load lookup valid.
REQ-012 load_addr  input  32  load byte address.
REQ-013 load_hazard  output  1  load word address matches a pending queue entry.
REQ-014 bus_valid  output  1  head entry presented to backing memory.
REQ-015 bus_ready  input  1  backing memory accepts head entry this cycle.
REQ-016 bus_addr  output  32  head word address, bits [1:0] forced 0.
REQ-017 bus_data  output  32  head data.
REQ-018 bus_be  output  4  head byte enables.
REQ-019 pending  output  CNT_W  number of valid entries.
REQ-020 overflow_err  output  1  sticky: write arrived while full and could not merge.

Function
REQ-021 Queue SHALL be a circular FIFO of DEPTH entries {word addr[31:2], data, be}, head/tail pointers wrapping modulo DEPTH.
REQ-022 wr_stall SHALL equal (pending == DEPTH), combinational from registered state.
REQ-023 mem_wr_en with byte_enable == 4'b0000 SHALL be ignored (no enqueue, no merge, no error).
REQ-024 Merge: if pending > 0, word address equals tail entry's, and the tail entry is not being popped this cycle, the write SHALL merge into the tail: each enabled lane overwrites data, tail be |= mem_wr_byte_enable; pending unchanged.
REQ-025 Otherwise, if pending < DEPTH, the write SHALL enqueue a new entry at the tail.
REQ-026 Otherwise (full, no merge), the write SHALL be dropped and overflow_err SHALL set to 1 and remain 1 until reset.
REQ-027 bus_valid SHALL equal (pending != 0); bus_addr/bus_data/bus_be SHALL reflect the head entry combinationally from registers.
REQ-028 Pop SHALL occur on a cycle with bus_valid && bus_ready; head advances by one.
REQ-029 Bus outputs SHALL remain stable while bus_valid && !bus_ready.
REQ-030 Enqueue and pop on the same cycle SHALL leave pending unchanged; a full queue SHALL NOT accept a new entry on a popping cycle (wr_stall is registered-state based).
REQ-031 Latency: a write enqueued into an empty queue in cycle N SHALL appear with bus_valid = 1 in cycle N+1, never in cycle N.
REQ-032 If pending == 1 and the head is popped in the same cycle as a same-word write, the write SHALL enqueue as a new entry (no merge into a departing entry).
REQ-033 load_hazard SHALL equal load_req && (some valid entry's word address == load_addr[31:2]); the write arriving in the same cycle is excluded.
REQ-034 pending SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-035 On rst_n low, asynchronously: pending = 0, head = tail = 0, bus_valid = 0, wr_stall = 0, load_hazard = 0 when load_req = 0, overflow_err = 0; bus_addr/bus_data/bus_be = 0.
REQ-036 Reset asserted mid-operation SHALL discard all pending entries without presenting them on the bus.
REQ-037 First write SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-038 Single write: addr 0x100, data 0xDEADBEEF, be 4'hF, bus_ready = 1 -> next cycle bus_valid = 1, bus_addr 0x100, data 0xDEADBEEF; the cycle after, pending = 0.
REQ-039 Merge: bus_ready = 0; write 0x200 data 0x000000AA be 4'h1, then 0x202 data 0x00BB0000 be 4'h4 -> pending = 1, bus_data 0x00BB00AA, bus_be 4'h5.
REQ-040 Fill/overflow: bus_ready = 0; writes to 0x0, 0x4, 0x8, 0xC -> wr_stall = 1; write to 0x10 -> dropped, overflow_err = 1; write to 0xC be 4'h2 -> merges, no change to pending.
REQ-041 Wrap: 10 writes to distinct addresses with bus_ready toggling every cycle -> bus drains all 10 in order, data intact; pending returns to 0.
REQ-042 Hazard: pending entry at 0x300; load_req with load_addr 0x302 -> load_hazard = 1; load_addr 0x304 -> 0; after pop -> 0.
REQ-043 Reset mid-drain: 3 entries pending, assert rst_n low mid-cycle -> bus_valid and pending drop to 0 immediately, overflow_err = 0.
